trg_ctrl: RTL and testbench
===========================

Name: trg_ctrl

Overview:
Trigger controller that sequences the NUM_STAGES trigger stage instances of the logic analyzer core.
- Decodes the long-command opcodes from the UART command decoder into per-stage mask/value/config load strobes.
- Handles the arm and reset commands.
- Owns the shared trigger-level counter the stages compare against.
- Runs the IDLE/ARMED/FIRED state machine whose output starts the sampler.

Parameters:
NUM_STAGES, 4, number of trigger stages served (1..4)
LVL_W, 2, width of trigger-level counter
CMD_W, 32, width of command payload forwarded to stages

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
opc_i  in  8  command opcode
cmd_i  in  CMD_W  command payload
exe_i  in  1  one-cycle strobe; opc_i/cmd_i valid
stb_i  in  1  sample strobe from sampler
cmd_o  out  CMD_W  registered payload broadcast to all stages
set_mask_o  out  NUM_STAGES  one-hot mask load strobe
set_val_o  out  NUM_STAGES  one-hot value load strobe
set_cfg_o  out  NUM_STAGES  one-hot config load strobe
arm_o  out  1  one-cycle arm pulse to all stages
lvl_o  out  LVL_W  current trigger level to all stages
match_i  in  NUM_STAGES  per-stage match flags
run_i  in  NUM_STAGES  per-stage run requests
armed_o  out  1  high in ARMED
run_o  out  1  one-cycle start pulse to sampler on trigger

Behaviour:
- Reset (rst_i=1): state IDLE; all outputs 0; lvl_o=0; cmd_o=0. Reset mid-operation aborts immediately and drops armed_o the next cycle.
- Opcode decode, on exe_i=1 only:
  - 0x00 = soft reset: same effect as rst_i, except cmd_o is held.
  - 0x01 = arm.
  - 0xC0 | (n<<2) | k, with n = stage 0..3 and k=0 mask, k=1 value, k=2 config.
  - k=3, n>=NUM_STAGES and every other opcode are ignored: no strobe, no state change.
- Load latency: exe_i at cycle t gives cmd_o=cmd_i and exactly one set_*_o[n] bit high during cycle t+1, for one cycle. cmd_o holds its value until the next accepted 0xC_ command.
- Arm: exe_i with 0x01 at t gives arm_o=1 for one cycle at t+1, lvl_o=0, and state ARMED from t+1. Arming in ARMED or FIRED re-arms the same way.
- States:
  - IDLE -> ARMED on arm.
  - ARMED, on stb_i=1:
    - if |run_i: run_o=1 next cycle and state -> FIRED.
    - else if |match_i: lvl_o increments by 1, saturating at 2^LVL_W-1 with no wrap.
    - run_i takes priority over match_i in the same cycle.
  - ARMED, stb_i=0: match_i/run_i ignored.
  - FIRED: run_o deasserts after one cycle; lvl_o frozen; leaves only on arm, soft reset or rst_i.
- armed_o = (state==ARMED).
- Simultaneous events:
  - arm command and stb_i with |run_i in the same cycle: arm wins; no run_o; lvl_o=0.
  - soft reset beats arm, which is impossible in the same cycle anyway since there is a single opcode.
- Load commands are accepted in any state and do not change state or level.
- In IDLE, match_i/run_i are ignored.

Decomposition:
- Package trg_pkg holds:
  - opcode constants OPC_RESET=8'h00, OPC_ARM=8'h01, OPC_TRG_BASE=8'hC0;
  - enum trg_state_t {IDLE, ARMED, FIRED};
  - localparam LVL_MAX.
- One natural sub-module, trg_opc_dec: combinational opcode to one-hot strobe decoder, registered in trg_ctrl.
- The level/FSM logic stays inline.

Test Plan:
- exe_i with opc=0xC5, cmd=0xDEADBEEF, NUM_STAGES=4 -> next cycle cmd_o=0xDEADBEEF, set_val_o=4'b0010, other strobes 0, for one cycle only.
- opc=0xCC with NUM_STAGES=2, and opc=0xC3 -> no strobe, state unchanged.
- Arm, then 3 strobes with match_i=4'b0001, run_i=0 -> lvl_o 0->1->2->3.
- Arm, then 5 strobes with match_i=4'b0001, run_i=0 -> lvl_o saturates at 3 with no wrap.
- ARMED, stb_i=1, match_i=4'b0100, run_i=4'b0100 -> run_o=1 for exactly one cycle, state FIRED, lvl_o unchanged.
- Further stb_i/run_i in FIRED -> no new run_o.
- ARMED at lvl 2, then soft reset 0x00 -> armed_o=0, lvl_o=0 next cycle.
- Separately, rst_i for one cycle in FIRED -> all outputs 0.
- Same cycle: exe_i opc=0x01 and stb_i with run_i=4'b0001 while ARMED at lvl 1 -> arm_o pulse, lvl_o=0, no run_o, state ARMED.

Source files
------------

// File: rtl/trg_pkg.sv
// Shared opcode constants, FSM state type and level limits for the trigger controller.
package trg_pkg;

  localparam logic [7:0] OPC_RESET    = 8'h00;
  localparam logic [7:0] OPC_ARM      = 8'h01;
  localparam logic [7:0] OPC_TRG_BASE = 8'hC0;

  localparam int                    LVL_W_DFLT = 2;
  localparam logic [LVL_W_DFLT-1:0] LVL_MAX    = '1;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} trg_state_t;

endpackage

// File: rtl/trg_ctrl_opc_dec.sv
// Combinational opcode decoder: 0xC0|(n<<2)|k -> one-hot per-stage load strobe.
module trg_opc_dec
  import trg_pkg::*;
#(
  parameter int NUM_STAGES = 4
) (
  input  logic [7:0]            opc,
  output logic                  srst,
  output logic                  arm,
  output logic                  load,
  output logic [NUM_STAGES-1:0] mask,
  output logic [NUM_STAGES-1:0] val,
  output logic [NUM_STAGES-1:0] cfg
);

  logic       hit;
  logic [1:0] n, k;

  assign n    = opc[3:2];
  assign k    = opc[1:0];
  assign hit  = (opc[7:4] == OPC_TRG_BASE[7:4]) && (k != 2'd3);
  assign srst = (opc == OPC_RESET);
  assign arm  = (opc == OPC_ARM);

  // Stages beyond NUM_STAGES have no generated strobe, so they decode to nothing.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign mask[s] = hit && (n == 2'(s)) && (k == 2'd0);
    assign val[s]  = hit && (n == 2'(s)) && (k == 2'd1);
    assign cfg[s]  = hit && (n == 2'(s)) && (k == 2'd2);
  end

  assign load = |{mask, val, cfg};

endmodule

// File: rtl/trg_ctrl.sv
// Trigger controller: command decode into stage load strobes, arm/reset, level counter and IDLE/ARMED/FIRED FSM.
module trg_ctrl
  import trg_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int LVL_W      = LVL_W_DFLT,
  parameter int CMD_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            opc_i,
  input  logic [CMD_W-1:0]      cmd_i,
  input  logic                  exe_i,
  input  logic                  stb_i,
  output logic [CMD_W-1:0]      cmd_o,
  output logic [NUM_STAGES-1:0] set_mask_o,
  output logic [NUM_STAGES-1:0] set_val_o,
  output logic [NUM_STAGES-1:0] set_cfg_o,
  output logic                  arm_o,
  output logic [LVL_W-1:0]      lvl_o,
  input  logic [NUM_STAGES-1:0] match_i,
  input  logic [NUM_STAGES-1:0] run_i,
  output logic                  armed_o,
  output logic                  run_o
);

  logic                  d_srst, d_arm, d_load;
  logic [NUM_STAGES-1:0] d_mask, d_val, d_cfg;
  trg_state_t            state;

  trg_opc_dec #(.NUM_STAGES(NUM_STAGES)) u_dec (
    .opc  (opc_i),
    .srst (d_srst),
    .arm  (d_arm),
    .load (d_load),
    .mask (d_mask),
    .val  (d_val),
    .cfg  (d_cfg)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cmd_o      <= '0;
      set_mask_o <= '0;
      set_val_o  <= '0;
      set_cfg_o  <= '0;
      arm_o      <= 1'b0;
      lvl_o      <= '0;
      armed_o    <= 1'b0;
      run_o      <= 1'b0;
    end else begin
      set_mask_o <= exe_i ? d_mask : '0;
      set_val_o  <= exe_i ? d_val  : '0;
      set_cfg_o  <= exe_i ? d_cfg  : '0;
      arm_o      <= 1'b0;
      run_o      <= 1'b0;
      if (exe_i && d_load) cmd_o <= cmd_i;
      // Arm/soft reset take precedence over any strobe in the same cycle.
      if (exe_i && d_srst) begin
        state   <= IDLE;
        lvl_o   <= '0;
        armed_o <= 1'b0;
      end else if (exe_i && d_arm) begin
        state   <= ARMED;
        lvl_o   <= '0;
        arm_o   <= 1'b1;
        armed_o <= 1'b1;
      end else if (state == ARMED && stb_i) begin
        if (|run_i) begin
          state   <= FIRED;
          run_o   <= 1'b1;
          armed_o <= 1'b0;
        end else if (|match_i && lvl_o != '1) begin
          lvl_o <= lvl_o + LVL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trg_ctrl.sv
// Scoreboard bench for trg_ctrl: a 4-stage and a 2-stage instance share stimulus.
module tb_trg_ctrl;
  import trg_pkg::*;

  logic        clk = 0;
  logic        rst, exe, stb;
  logic [7:0]  opc;
  logic [31:0] cmd;
  logic [3:0]  match, run;

  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  mask_a, val_a, cfg_a;
  logic [1:0]  mask_b, val_b, cfg_b, lvl_a, lvl_b;
  logic        arm_a, arm_b, armed_a, armed_b, run_a, run_b;

  always #5 clk = ~clk;

  trg_ctrl #(.NUM_STAGES(4), .LVL_W(2), .CMD_W(32)) u_a (
    .clk_i(clk), .rst_i(rst), .opc_i(opc), .cmd_i(cmd), .exe_i(exe), .stb_i(stb),
    .cmd_o(cmd_a), .set_mask_o(mask_a), .set_val_o(val_a), .set_cfg_o(cfg_a),
    .arm_o(arm_a), .lvl_o(lvl_a), .match_i(match), .run_i(run),
    .armed_o(armed_a), .run_o(run_a)
  );

  // Narrow instance: OR-fold the flags so its level/FSM tracks the wide one.
  trg_ctrl #(.NUM_STAGES(2), .LVL_W(2), .CMD_W(32)) u_b (
    .clk_i(clk), .rst_i(rst), .opc_i(opc), .cmd_i(cmd), .exe_i(exe), .stb_i(stb),
    .cmd_o(cmd_b), .set_mask_o(mask_b), .set_val_o(val_b), .set_cfg_o(cfg_b),
    .arm_o(arm_b), .lvl_o(lvl_b), .match_i(match[1:0] | match[3:2]),
    .run_i(run[1:0] | run[3:2]), .armed_o(armed_b), .run_o(run_b)
  );

  typedef struct {
    logic [31:0] cmd, cmd2;
    logic [3:0]  mask, val, cfg;
    logic [1:0]  mask2, val2, cfg2, lvl;
    logic        arm, armed, run;
  } exp_t;

  exp_t q[$];
  int   vecs = 0, errs = 0;

  int          m_state = 0;  // 0 idle, 1 armed, 2 fired
  logic [1:0]  m_lvl = 0;
  logic [31:0] m_cmd = 0, m_cmd2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle and push the outputs the spec requires after the edge.
  task automatic cyc(input logic r, input logic e, input logic [7:0] o, input logic [31:0] c,
                     input logic s, input logic [3:0] mt, input logic [3:0] rn);
    exp_t x;
    int   n, k;
    @(negedge clk);
    rst = r; exe = e; opc = o; cmd = c; stb = s; match = mt; run = rn;
    x.mask = 0; x.val = 0; x.cfg = 0; x.mask2 = 0; x.val2 = 0; x.cfg2 = 0;
    x.arm = 0; x.run = 0;
    n = int'(o[3:2]); k = int'(o[1:0]);
    if (r) begin
      m_state = 0; m_lvl = 0; m_cmd = 0; m_cmd2 = 0;
    end else begin
      if (e && o[7:4] == 4'hC && k != 3) begin
        m_cmd = c;
        if (k == 0) x.mask[n] = 1; else if (k == 1) x.val[n] = 1; else x.cfg[n] = 1;
        if (n < 2) begin
          m_cmd2 = c;
          if (k == 0) x.mask2[n] = 1; else if (k == 1) x.val2[n] = 1; else x.cfg2[n] = 1;
        end
      end
      if (e && o == OPC_RESET) begin
        m_state = 0; m_lvl = 0;
      end else if (e && o == OPC_ARM) begin
        m_state = 1; m_lvl = 0; x.arm = 1;
      end else if (m_state == 1 && s) begin
        if (rn != 0) begin
          m_state = 2; x.run = 1;
        end else if (mt != 0 && m_lvl != LVL_MAX) begin
          m_lvl = m_lvl + 2'd1;
        end
      end
    end
    x.cmd = m_cmd; x.cmd2 = m_cmd2; x.lvl = m_lvl; x.armed = (m_state == 1);
    q.push_back(x);
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 32'h0, 0, 4'h0, 4'h0);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("cmd",    cmd_a,   x.cmd);
      chk("mask",   mask_a,  {28'h0, x.mask});
      chk("val",    val_a,   {28'h0, x.val});
      chk("cfg",    cfg_a,   {28'h0, x.cfg});
      chk("arm",    arm_a,   {31'h0, x.arm});
      chk("lvl",    lvl_a,   {30'h0, x.lvl});
      chk("armed",  armed_a, {31'h0, x.armed});
      chk("run",    run_a,   {31'h0, x.run});
      chk("cmd2",   cmd_b,   x.cmd2);
      chk("strb2",  {mask_b, val_b, cfg_b}, {26'h0, x.mask2, x.val2, x.cfg2});
      chk("fsm2",   {arm_b, armed_b, run_b, lvl_b}, {27'h0, x.arm, x.armed, x.run, x.lvl});
    end
  end

  localparam logic [7:0] RND_OPC [8] = '{8'h00, 8'h01, 8'hC5, 8'hCC, 8'hC3, 8'hCA, 8'h7F, 8'hC0};

  initial begin
    rst = 1; exe = 0; opc = 0; cmd = 0; stb = 0; match = 0; run = 0;
    cyc(1, 0, 8'h00, 32'h0, 0, 4'h0, 4'h0);
    cyc(1, 1, 8'hC5, 32'hFFFF_FFFF, 1, 4'hF, 4'hF);
    idle(1);
    // loads and ignored opcodes
    cyc(0, 1, 8'hC5, 32'hDEAD_BEEF, 0, 4'h0, 4'h0);
    idle(1);
    cyc(0, 1, 8'hCC, 32'h1234_5678, 0, 4'h0, 4'h0);
    cyc(0, 1, 8'hC3, 32'hAAAA_0000, 0, 4'h0, 4'h0);
    cyc(0, 1, 8'hC2, 32'h0000_C0F6, 0, 4'h0, 4'h0);
    cyc(0, 1, 8'hCE, 32'h5555_AAAA, 0, 4'h0, 4'h0);
    cyc(0, 0, 8'hC4, 32'h0BAD_0BAD, 0, 4'h0, 4'h0);
    cyc(0, 1, 8'h55, 32'h0BAD_0BAD, 1, 4'hF, 4'hF);
    // arm, climb and saturate the level
    cyc(0, 1, 8'h01, 32'h0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 32'h0, 1, 4'b0001, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 0, 4'hF, 4'hF);
    // fire, then further strobes in FIRED
    cyc(0, 0, 8'h00, 32'h0, 1, 4'b0100, 4'b0100);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'h0, 4'b0001);
    // soft reset at level 2
    cyc(0, 1, 8'h01, 32'h0, 0, 4'h0, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'b1000, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'b0010, 4'h0);
    cyc(0, 1, 8'h00, 32'h0, 0, 4'h0, 4'h0);
    idle(1);
    // hard reset while FIRED
    cyc(0, 1, 8'h01, 32'h0, 0, 4'h0, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'h0, 4'b1000);
    cyc(1, 0, 8'h00, 32'h0, 0, 4'h0, 4'h0);
    idle(1);
    // arm collides with a run strobe at level 1
    cyc(0, 1, 8'h01, 32'h0, 0, 4'h0, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'b0001, 4'h0);
    cyc(0, 1, 8'h01, 32'h0, 1, 4'h0, 4'b0001);
    idle(1);
    // load while ARMED alongside a match strobe
    cyc(0, 1, 8'hC9, 32'hCAFE_F00D, 1, 4'b0010, 4'h0);
    cyc(0, 0, 8'h00, 32'h0, 1, 4'h0, 4'b0010);
    // random mix
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), RND_OPC[$urandom_range(0, 7)],
          $urandom, $urandom_range(0, 1), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
